vector_store_unit: RTL

Sequential write-back stage downstream of the five-lane vector ALU. On `start` it captures the five 32-bit lane results plus a base address. It then writes them to data memory one word per cycle at consecutive word addresses, stalling the core until the last store is accepted. This lets a vector instruction commit through the single scalar memory write port.

---
 rtl/vector_store_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vector_store_unit.sv
// Vector store unit: captures five lane results and a base address, then writes
// them to data memory one word per cycle at consecutive word addresses while
// stalling the core.
module vector_store_unit #(
    parameter int LANES = 5,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base_addr,
    input  logic [WIDTH-1:0] elem_0,
    input  logic [WIDTH-1:0] elem_1,
    input  logic [WIDTH-1:0] elem_2,
    input  logic [WIDTH-1:0] elem_3,
    input  logic [WIDTH-1:0] elem_4,
    input  logic             mem_ready,
    output logic             MemWrite,
    output logic [WIDTH-1:0] DataAdr,
    output logic [WIDTH-1:0] WriteData,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle,
        StStore,
        StDone
    } state_t;

    localparam logic [2:0] LastIdx = 3'(LANES - 1);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [WIDTH-1:0] elem_q [LANES];
    logic [WIDTH-1:0] base_q;
    logic             capture;
    logic [WIDTH-1:0] lane_data;

    // State and lane index registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Operand capture; only the latched copies are used during the store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                elem_q[i] <= '0;
            end
            base_q <= '0;
        end else if (capture) begin
            elem_q[0] <= elem_0;
            elem_q[1] <= elem_1;
            elem_q[2] <= elem_2;
            elem_q[3] <= elem_3;
            elem_q[4] <= elem_4;
            base_q    <= base_addr;
        end
    end

    // Select the lane currently being written.
    always_comb begin
        lane_data = '0;
        case (idx_q)
            3'd0:    lane_data = elem_q[0];
            3'd1:    lane_data = elem_q[1];
            3'd2:    lane_data = elem_q[2];
            3'd3:    lane_data = elem_q[3];
            3'd4:    lane_data = elem_q[4];
            default: lane_data = '0;
        endcase
    end

    // Next-state logic and outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        capture   = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        busy      = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        case (state_q)
            StIdle: begin
                // Stall combinationally so the core freezes in the request cycle.
                stall = start;
                if (start) begin
                    capture = 1'b1;
                    idx_d   = 3'd0;
                    state_d = StStore;
                end
            end
            StStore: begin
                MemWrite  = 1'b1;
                DataAdr   = base_q + (WIDTH'(idx_q) << 2);
                WriteData = lane_data;
                busy      = 1'b1;
                stall     = 1'b1;
                if (mem_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
